axi4_lite_slave_regfile: RTL and testbench
==========================================

# axi4_lite_slave_regfile

Parametrised AXI4-Lite slave register file: the next generation of the team's basic AXI4-Lite slave, with configurable register count and data width, byte-lane write strobes, independent AW/W acceptance, full VALID/READY backpressure on B and R, and SLVERR for out-of-range accesses. It sits behind the AXI4-Lite interconnect as a control/status register bank. All register contents are exported flat to user logic.

## Interface
- p_DATA_WIDTH, 32, data bus width in bits; multiple of 8, at least 8.
- p_ADDRESS_WIDTH, 8, byte address width.
- p_NUM_REGS, 8, number of registers; at most 2**(p_ADDRESS_WIDTH - log2(p_DATA_WIDTH/8)).
- lp_STROBE_WIDTH (local), p_DATA_WIDTH/8, byte lanes.

Ports:
- i_ACLK  in  1  clock, all logic on rising edge.
- i_ARESETN  in  1  reset; one clock; reset is synchronous and active-low.
- i_M_AWADDR  in  p_ADDRESS_WIDTH  write byte address.
- i_M_AWPROT  in  3  ignored.
- i_M_AWVALID  in  1; o_S_AWREADY  out  1.
- i_M_WDATA  in  p_DATA_WIDTH; i_M_WSTRB  in  lp_STROBE_WIDTH  byte enables.
- i_M_WVALID  in  1; o_S_WREADY  out  1.
- o_S_BRESP  out  2; o_S_BVALID  out  1; i_M_BREADY  in  1.
- i_M_ARADDR  in  p_ADDRESS_WIDTH; i_M_ARPROT  in  3  ignored.
- i_M_ARVALID  in  1; o_S_ARREADY  out  1.
- o_S_RDATA  out  p_DATA_WIDTH; o_S_RRESP  out  2; o_S_RVALID  out  1; i_M_RREADY  in  1.
- o_REGS  out  p_NUM_REGS*p_DATA_WIDTH  register contents, register k at bits [k*p_DATA_WIDTH +: p_DATA_WIDTH].

## Operation
- Register index = address >> log2(lp_STROBE_WIDTH); low address bits ignored. Index >= p_NUM_REGS is out of range.
- Reset (i_ARESETN=0 at an edge): all registers 0; every output 0 (AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA). Reset mid-transaction discards held AW/W and pending B/R.
- Write path: AW and W captured independently into holding registers, in either order or same cycle. o_S_AWREADY registered, high iff no AW held and BVALID low; same for o_S_WREADY with W.
- Write commit: at the edge where the second of AW/W completes (or both together), write lane i of the register iff WSTRB[i]=1; BVALID<=1, BRESP<=00 (OKAY) in range, 10 (SLVERR) out of range with no register change.
- BVALID held with BRESP stable until BVALID&BREADY; at that edge BVALID<=0, holds cleared, AWREADY/WREADY<=1.
- Read path: o_S_ARREADY registered, high iff RVALID low. On AR handshake: RDATA<=register (0 if out of range), RRESP<=00/10, RVALID<=1, ARREADY<=0.
- RVALID, RDATA, RRESP held stable until RVALID&RREADY; at that edge RVALID<=0, ARREADY<=1. RDATA keeps last value afterwards.
- Simultaneous write commit and read handshake to the same register: read returns pre-write value.
- WSTRB=0: handshake completes, BRESP OKAY, register unchanged.

## Timing
- First edge after reset release: AWREADY, WREADY, ARREADY go 1.
- Write: AW+W handshake at edge N -> BVALID=1 after N; register/o_REGS updated at N. BREADY high throughout -> next AW/W accepted at N+2 (one write per 2 cycles).
- AW at edge N, W at edge N+k: AWREADY=0 after N; commit and BVALID at N+k.
- Read: AR handshake at edge N -> RVALID=1 after N; RREADY high -> next AR at N+2.
- Read and write channels fully independent; no ordering between them except the same-edge rule above.
- No combinational path from any input to any output.

## Test plan
- Reset: drive i_ARESETN=0 mid-write (AW held) -> all outputs 0, register unchanged; after release READYs=1 next cycle.
- Write 0xDEADBEEF to 0x04, WSTRB=1111, then read 0x04 -> BRESP=00, RDATA=0xDEADBEEF, RRESP=00, o_REGS reg1=0xDEADBEEF.
- Write 0x11223344 WSTRB=0101 over 0xDEADBEEF at 0x04 -> reads 0xDE22BE44.
- W presented 3 cycles before AW, BREADY low 4 cycles -> WREADY low after W, BVALID held with BRESP stable, no second write accepted until B handshake.
- Access 0x40 with p_NUM_REGS=8 -> BRESP=10, no register changes; read RDATA=0, RRESP=10.
- Same-edge read and write commit to 0x00 (old 0x5, new 0x9) -> RDATA=0x5, subsequent read 0x9; RREADY low 5 cycles keeps RDATA stable.

Source files
------------

// File: rtl/axi4_lite_slave_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave_regfile_if
// Brief    : AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
// Revision : 1.0
// ============================================================================
interface axi4_lite_slave_regfile_if #(
    parameter int p_DATA_WIDTH    = 32,
    parameter int p_ADDRESS_WIDTH = 8
);
    localparam int lp_STROBE_WIDTH = p_DATA_WIDTH / 8;

    logic [p_ADDRESS_WIDTH-1:0] awaddr;
    logic [2:0]                 awprot;
    logic                       awvalid;
    logic                       awready;

    logic [p_DATA_WIDTH-1:0]    wdata;
    logic [lp_STROBE_WIDTH-1:0] wstrb;
    logic                       wvalid;
    logic                       wready;

    logic [1:0]                 bresp;
    logic                       bvalid;
    logic                       bready;

    logic [p_ADDRESS_WIDTH-1:0] araddr;
    logic [2:0]                 arprot;
    logic                       arvalid;
    logic                       arready;

    logic [p_DATA_WIDTH-1:0]    rdata;
    logic [1:0]                 rresp;
    logic                       rvalid;
    logic                       rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave_regfile
// Brief    : AXI4-Lite slave register bank with byte strobes, SLVERR decode
//            and flat export of all register contents.
// Revision : 1.0
// ============================================================================
module axi4_lite_slave_regfile #(
    parameter int p_DATA_WIDTH    = 32,
    parameter int p_ADDRESS_WIDTH = 8,
    parameter int p_NUM_REGS      = 8
) (
    input  wire logic                               i_ACLK,
    input  wire logic                               i_ARESETN,
    axi4_lite_slave_regfile_if.slave                s_axi,
    output logic [p_NUM_REGS*p_DATA_WIDTH-1:0]      o_REGS
);
    localparam int         lp_STROBE_WIDTH = p_DATA_WIDTH / 8;
    localparam int         c_IDX_SHIFT     = $clog2(lp_STROBE_WIDTH);
    localparam int         c_CMP_W         = p_ADDRESS_WIDTH + 1;
    localparam logic [1:0] c_RESP_OKAY     = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR   = 2'b10;

    logic [p_DATA_WIDTH-1:0]    r_regs [p_NUM_REGS];

    logic                       r_aw_held;
    logic [p_ADDRESS_WIDTH-1:0] r_aw_addr;
    logic                       r_w_held;
    logic [p_DATA_WIDTH-1:0]    r_w_data;
    logic [lp_STROBE_WIDTH-1:0] r_w_strb;
    logic                       r_awready;
    logic                       r_wready;
    logic                       r_bvalid;
    logic [1:0]                 r_bresp;

    logic                       r_arready;
    logic                       r_rvalid;
    logic [p_DATA_WIDTH-1:0]    r_rdata;
    logic [1:0]                 r_rresp;

    logic                       w_aw_hs;
    logic                       w_w_hs;
    logic                       w_aw_have;
    logic                       w_w_have;
    logic                       w_commit;
    logic [p_ADDRESS_WIDTH-1:0] w_wr_addr;
    logic [p_DATA_WIDTH-1:0]    w_wr_data;
    logic [lp_STROBE_WIDTH-1:0] w_wr_strb;
    logic [p_ADDRESS_WIDTH-1:0] w_wr_idx;
    logic                       w_wr_in_range;
    logic                       w_bvalid_next;
    logic                       w_aw_held_next;
    logic                       w_w_held_next;

    logic                       w_ar_hs;
    logic                       w_rd_hs;
    logic [p_ADDRESS_WIDTH-1:0] w_rd_idx;
    logic                       w_rd_in_range;
    logic [p_DATA_WIDTH-1:0]    w_rd_data;

    logic                       w_unused;

    // Protection attributes carry no meaning for this register bank.
    assign w_unused = ^{s_axi.awprot, s_axi.arprot};

    // A channel "has" its beat if it was held earlier or handshakes this edge;
    // the write commits at the edge where both halves become available.
    assign w_aw_hs   = s_axi.awvalid & r_awready;
    assign w_w_hs    = s_axi.wvalid  & r_wready;
    assign w_aw_have = r_aw_held | w_aw_hs;
    assign w_w_have  = r_w_held  | w_w_hs;
    assign w_commit  = w_aw_have & w_w_have;

    assign w_wr_addr     = w_aw_hs ? s_axi.awaddr : r_aw_addr;
    assign w_wr_data     = w_w_hs  ? s_axi.wdata  : r_w_data;
    assign w_wr_strb     = w_w_hs  ? s_axi.wstrb  : r_w_strb;
    assign w_wr_idx      = w_wr_addr >> c_IDX_SHIFT;
    assign w_wr_in_range = c_CMP_W'(w_wr_idx) < c_CMP_W'(p_NUM_REGS);

    assign w_bvalid_next  = w_commit | (r_bvalid & ~s_axi.bready);
    assign w_aw_held_next = w_aw_have & ~w_commit;
    assign w_w_held_next  = w_w_have  & ~w_commit;

    assign w_ar_hs       = s_axi.arvalid & r_arready;
    assign w_rd_hs       = r_rvalid & s_axi.rready;
    assign w_rd_idx      = s_axi.araddr >> c_IDX_SHIFT;
    assign w_rd_in_range = c_CMP_W'(w_rd_idx) < c_CMP_W'(p_NUM_REGS);

    // Out-of-range indices match no entry, so the mux yields zero for them.
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < p_NUM_REGS; k++) begin
            if (w_rd_idx == p_ADDRESS_WIDTH'(k)) begin
                w_rd_data = r_regs[k];
            end
        end
    end

    always_ff @(posedge i_ACLK) begin
        if (!i_ARESETN) begin
            r_aw_held <= 1'b0;
            r_aw_addr <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            for (int k = 0; k < p_NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            r_aw_held <= w_aw_held_next;
            r_w_held  <= w_w_held_next;
            if (w_aw_hs) begin
                r_aw_addr <= s_axi.awaddr;
            end
            if (w_w_hs) begin
                r_w_data <= s_axi.wdata;
                r_w_strb <= s_axi.wstrb;
            end
            r_bvalid  <= w_bvalid_next;
            r_awready <= ~w_aw_held_next & ~w_bvalid_next;
            r_wready  <= ~w_w_held_next  & ~w_bvalid_next;
            if (w_commit) begin
                r_bresp <= w_wr_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
            end
            for (int k = 0; k < p_NUM_REGS; k++) begin
                for (int b = 0; b < lp_STROBE_WIDTH; b++) begin
                    if (w_commit && w_wr_in_range && w_wr_strb[b] &&
                        (w_wr_idx == p_ADDRESS_WIDTH'(k))) begin
                        r_regs[k][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Read data is taken from the pre-edge register value, so a read that
    // coincides with a write commit to the same register sees the old data.
    always_ff @(posedge i_ACLK) begin
        if (!i_ARESETN) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
        end else if (w_ar_hs) begin
            r_rdata   <= w_rd_data;
            r_rresp   <= w_rd_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
        end else if (w_rd_hs) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
        end else begin
            r_arready <= ~r_rvalid;
        end
    end

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;

    generate
        for (genvar k = 0; k < p_NUM_REGS; k++) begin : g_regs_out
            assign o_REGS[k*p_DATA_WIDTH +: p_DATA_WIDTH] = r_regs[k];
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_slave_regfile
// Brief    : Vector table plus corner sequences, scored through B/R queues.
// Revision : 1.0
// ============================================================================
module tb_axi4_lite_slave_regfile;
    localparam int c_DW = 32;
    localparam int c_AW = 8;
    localparam int c_NR = 8;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    logic clk;
    logic rst_n;
    logic [c_NR*c_DW-1:0] regs_flat;
    logic [31:0] model [c_NR];
    exp_t bq[$];
    exp_t rq[$];
    vec_t vecs[15];
    int checks = 0;
    int failures = 0;

    axi4_lite_slave_regfile_if #(.p_DATA_WIDTH(c_DW), .p_ADDRESS_WIDTH(c_AW)) bus ();

    axi4_lite_slave_regfile #(
        .p_DATA_WIDTH(c_DW), .p_ADDRESS_WIDTH(c_AW), .p_NUM_REGS(c_NR)
    ) dut (
        .i_ACLK(clk), .i_ARESETN(rst_n), .s_axi(bus), .o_REGS(regs_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_write(input logic [7:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        int idx;
        idx = int'(addr >> 2);
        if (idx < c_NR) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
            end
        end
    endfunction

    task automatic check_regs(input string tag);
        for (int k = 0; k < c_NR; k++) begin
            check($sformatf("%s_reg%0d", tag, k), regs_flat[k*c_DW +: c_DW], model[k]);
        end
    endtask

    // Scoreboard: pop one expectation per B or R handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.bvalid && bus.bready) begin
                exp_t e;
                if (bq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_unexpected: got bresp=%0b with no write pending", bus.bresp);
                end else begin
                    e = bq.pop_front();
                    check("bresp", bus.bresp, e.resp);
                end
            end
            if (bus.rvalid && bus.rready) begin
                exp_t e;
                if (rq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL r_unexpected: got rdata=0x%0h with no read pending", bus.rdata);
                end else begin
                    e = rq.pop_front();
                    check("rdata", bus.rdata, e.data);
                    check("rresp", bus.rresp, e.resp);
                end
            end
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (bq.size() != 0 || rq.size() != 0) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got %0d B and %0d R responses outstanding, expected 0",
                     name, bq.size(), rq.size());
            bq.delete();
            rq.delete();
        end
    endtask

    task automatic put_write(input bit do_aw, input bit do_w, input logic [7:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
        bit aw_f, w_f;
        int n;
        @(posedge clk); #1;
        if (do_aw) begin bus.awaddr = addr; bus.awvalid = 1'b1; end
        if (do_w)  begin bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1; end
        n = 0;
        while ((bus.awvalid || bus.wvalid) && n < 20) begin
            @(negedge clk);
            aw_f = bus.awvalid && bus.awready;
            w_f  = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            if (aw_f) bus.awvalid = 1'b0;
            if (w_f)  bus.wvalid  = 1'b0;
            n++;
        end
        if (bus.awvalid || bus.wvalid) begin
            checks++; failures++;
            $display("FAIL write_accept_timeout: got awvalid=%0b wvalid=%0b pending, expected accepted",
                     bus.awvalid, bus.wvalid);
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
        end
    endtask

    task automatic put_read(input logic [7:0] addr);
        bit f;
        int n;
        @(posedge clk); #1;
        bus.araddr = addr;
        bus.arvalid = 1'b1;
        n = 0;
        while (bus.arvalid && n < 20) begin
            @(negedge clk);
            f = bus.arvalid && bus.arready;
            @(posedge clk); #1;
            if (f) bus.arvalid = 1'b0;
            n++;
        end
        if (bus.arvalid) begin
            checks++; failures++;
            $display("FAIL read_accept_timeout: got arvalid=1 pending, expected accepted");
            bus.arvalid = 1'b0;
        end
    endtask

    task automatic write_tx(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp);
        exp_t e;
        e.resp = resp;
        e.data = '0;
        bq.push_back(e);
        put_write(1'b1, 1'b1, addr, data, strb);
        model_write(addr, data, strb);
        drain("write");
    endtask

    task automatic read_tx(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] resp);
        exp_t e;
        e.resp = resp;
        e.data = data;
        rq.push_back(e);
        put_read(addr);
        drain("read");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        vecs[0]  = '{1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 8'h04, 32'h11223344, 4'h5, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'hDE22BE44};
        vecs[4]  = '{1'b1, 8'h40, 32'hCAFEF00D, 4'hF, 2'b10, 32'h0};
        vecs[5]  = '{1'b0, 8'h40, 32'h0,        4'h0, 2'b10, 32'h0};
        vecs[6]  = '{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'hDE22BE44};
        vecs[7]  = '{1'b1, 8'h1C, 32'hA5A5A5A5, 4'hF, 2'b00, 32'h0};
        vecs[8]  = '{1'b0, 8'h1F, 32'h0,        4'h0, 2'b00, 32'hA5A5A5A5};
        vecs[9]  = '{1'b1, 8'h20, 32'h01010101, 4'hF, 2'b10, 32'h0};
        vecs[10] = '{1'b1, 8'h10, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0};
        vecs[11] = '{1'b0, 8'h10, 32'h0,        4'h0, 2'b00, 32'h0};
        vecs[12] = '{1'b1, 8'h00, 32'h00000005, 4'hF, 2'b00, 32'h0};
        vecs[13] = '{1'b0, 8'h00, 32'h0,        4'h0, 2'b00, 32'h00000005};
        vecs[14] = '{1'b0, 8'h08, 32'h0,        4'h0, 2'b00, 32'h12345678};
        for (int k = 0; k < c_NR; k++) model[k] = '0;

        rst_n = 1'b0;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

        // Power-on reset and release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                              bus.bresp, bus.rresp}, '0);
        check("rst_rdata", bus.rdata, '0);
        check("rst_regs_zero", 64'(regs_flat == '0), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_readys", {bus.awready, bus.wready, bus.arready}, 3'b111);

        // Reset while an AW is held: the held address must be discarded.
        put_write(1'b1, 1'b0, 8'h08, 32'h0, 4'h0);
        @(negedge clk);
        check("aw_held_awready", bus.awready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_outputs", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                                 bus.bresp, bus.rresp}, '0);
        check_regs("midrst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_release_readys", {bus.awready, bus.wready, bus.arready}, 3'b111);

        // W three cycles ahead of AW, then BREADY low for four cycles.
        put_write(1'b0, 1'b1, 8'h00, 32'h12345678, 4'hF);
        @(negedge clk);
        check("w_held_wready", bus.wready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("w_only_bvalid%0d", i), bus.bvalid, 1'b0);
        end
        check_regs("w_only");
        bus.bready = 1'b0;
        put_write(1'b1, 1'b0, 8'h08, 32'h0, 4'h0);
        bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("bstall_bvalid%0d", i), bus.bvalid, 1'b1);
            check($sformatf("bstall_bresp%0d", i), bus.bresp, 2'b00);
            check($sformatf("bstall_readys%0d", i), {bus.awready, bus.wready}, 2'b00);
        end
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        e.resp = 2'b00; e.data = '0;
        bq.push_back(e);
        bus.bready = 1'b1;
        drain("bstall");
        model_write(8'h08, 32'h12345678, 4'hF);
        check_regs("bstall");

        // Vector table.
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                write_tx(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
                check_regs($sformatf("vec%0d", i));
            end else begin
                read_tx(vecs[i].addr, vecs[i].rdata, vecs[i].resp);
            end
        end

        // Same-edge write commit and read of register 0, RREADY low 5 cycles.
        e.resp = 2'b00; e.data = '0;
        bq.push_back(e);
        @(posedge clk); #1;
        bus.rready = 1'b0;
        bus.awaddr = 8'h00; bus.awvalid = 1'b1;
        bus.wdata = 32'h9; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.araddr = 8'h00; bus.arvalid = 1'b1;
        @(negedge clk);
        check("same_edge_readys", {bus.awready, bus.wready, bus.arready}, 3'b111);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("rstall_rvalid%0d", i), bus.rvalid, 1'b1);
            check($sformatf("rstall_rdata%0d", i), bus.rdata, 32'h5);
            check($sformatf("rstall_rresp%0d", i), bus.rresp, 2'b00);
            check($sformatf("rstall_arready%0d", i), bus.arready, 1'b0);
        end
        e.resp = 2'b00; e.data = 32'h5;
        rq.push_back(e);
        bus.rready = 1'b1;
        drain("same_edge");
        model_write(8'h00, 32'h9, 4'hF);
        check_regs("same_edge");
        read_tx(8'h00, 32'h9, 2'b00);
        @(negedge clk);
        check("rdata_kept", bus.rdata, 32'h9);
        check("rvalid_idle", bus.rvalid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
